// File: rtl/fmap_mem_pkg.sv
// Shared definitions for the feature-map memory responder.
// Holds the default geometry (lane width, lane count, depth), the derived word and address
// widths, and the sweep FSM state type.
package fmap_mem_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANES  = 16;
    // 112 x 112 pixels, 32 channels packed LANES per word
    localparam int unsigned DEPTH  = 25088;
    localparam int unsigned WORD_W = DATA_W * LANES;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

endpackage

// File: rtl/fmap_read_responder_if.sv
// Read/write bus between the feature-map store and its clients.
//   mem_en, mem_addr     : read request (requester -> responder), no backpressure
//   mem_dout, mem_valid  : in-order read response (responder -> requester)
//   wr_en, wr_addr,
//   wr_data              : write request (requester -> responder)
//   wr_ready             : responder currently accepts writes
// Modports: master = requester side, slave = responder side.
interface fmap_read_responder_if #(
    parameter int unsigned ADDR_W = fmap_mem_pkg::ADDR_W,
    parameter int unsigned WORD_W = fmap_mem_pkg::WORD_W
) ();

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_dout;
    logic              mem_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output mem_en, mem_addr, wr_en, wr_addr, wr_data,
        input  mem_dout, mem_valid, wr_ready
    );

    modport slave (
        input  mem_en, mem_addr, wr_en, wr_addr, wr_data,
        output mem_dout, mem_valid, wr_ready
    );

endinterface

// File: rtl/fmap_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, read-first on address collision,
// registered read data (1-cycle latency). No reset on the array or the read register so it
// maps onto block/ultra RAM.
//   clk            : clock
//   we, waddr, wdata : write port
//   re, raddr      : read port enable/address
//   rdata          : read data, valid the cycle after re
module fmap_sdp_ram #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DEPTH  = 25088,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-cycle read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fmap_read_responder.sv
// Memory-side responder for the feature-map read interface.
// Every read request is answered exactly once, in order, READ_LAT cycles later. A write port
// loads feature maps; a clear sweep zeroes the whole array one word per cycle.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : read request/response and write port (slave side)
//   clear_start : start a zero sweep (ignored while one is running)
//   busy        : sweep in progress
//   err_oob     : sticky out-of-range access flag
//   err_clr     : clears err_oob (a new out-of-range event in the same cycle wins)
//   rd_count    : wrapping count of responses issued
module fmap_read_responder #(
    parameter int unsigned DATA_W   = fmap_mem_pkg::DATA_W,
    parameter int unsigned LANES    = fmap_mem_pkg::LANES,
    parameter int unsigned DEPTH    = fmap_mem_pkg::DEPTH,
    // Legal range 1..4
    parameter int unsigned READ_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    fmap_read_responder_if.slave         bus,
    input  logic                         clear_start,
    output logic                         busy,
    output logic                         err_oob,
    input  logic                         err_clr,
    output logic [15:0]                  rd_count
);

    import fmap_mem_pkg::*;

    localparam int unsigned WORD_W = DATA_W * LANES;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    // One extra bit so the range compare stays correct when DEPTH is a power of two
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    logic              rd_in_range, wr_in_range;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;
    logic              wr_oob;

    logic              vld0_q, zero0_q;
    logic [WORD_W-1:0] s0_word;
    logic              out_vld;
    logic [WORD_W-1:0] out_word;
    logic              err_q;
    logic [15:0]       rd_count_q;

    assign rd_in_range = {1'b0, bus.mem_addr} < DEPTH_EXT;
    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_EXT;

    // ---------------- sweep FSM and write mux ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ram_we    = 1'b0;
        ram_waddr = bus.wr_addr;
        ram_wdata = bus.wr_data;
        wr_oob    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ram_we = bus.wr_en && wr_in_range;
                wr_oob = bus.wr_en && !wr_in_range;
                if (clear_start) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end
            end
            StClear: begin
                // User writes are dropped silently while the sweep owns the write port.
                ram_we    = 1'b1;
                ram_waddr = clr_ptr_q;
                ram_wdata = '0;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = StIdle;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy         = (state_q == StClear);
    assign bus.wr_ready = (state_q == StIdle);

    // ---------------- storage ----------------
    fmap_sdp_ram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (bus.mem_en && rd_in_range),
        .raddr (bus.mem_addr),
        .rdata (ram_rdata)
    );

    // ---------------- read response pipeline ----------------
    // Stage 0 flags line up with the RAM output register; the zero flag covers out-of-range
    // reads and reads accepted during the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0_q  <= 1'b0;
            zero0_q <= 1'b0;
        end else begin
            vld0_q  <= bus.mem_en;
            zero0_q <= !rd_in_range || (state_q == StClear);
        end
    end

    assign s0_word = zero0_q ? '0 : ram_rdata;

    if (READ_LAT <= 1) begin : g_lat1
        assign out_vld  = vld0_q;
        assign out_word = s0_word;
    end else begin : g_pipe
        localparam int unsigned STAGES = READ_LAT - 1;

        logic [STAGES-1:0] vld_pipe_q;
        logic [WORD_W-1:0] word_pipe_q [STAGES];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pipe_q <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    word_pipe_q[i] <= '0;
                end
            end else begin
                vld_pipe_q[0]  <= vld0_q;
                word_pipe_q[0] <= s0_word;
                for (int i = 1; i < STAGES; i++) begin
                    vld_pipe_q[i]  <= vld_pipe_q[i-1];
                    word_pipe_q[i] <= word_pipe_q[i-1];
                end
            end
        end

        assign out_vld  = vld_pipe_q[STAGES-1];
        assign out_word = word_pipe_q[STAGES-1];
    end

    assign bus.mem_valid = out_vld;
    assign bus.mem_dout  = out_vld ? out_word : '0;

    // ---------------- error flag and response counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            rd_count_q <= '0;
        end else begin
            if ((bus.mem_en && !rd_in_range) || wr_oob) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (out_vld) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign err_oob  = err_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fmap_read_responder.sv
// Scoreboard bench for fmap_read_responder. The driver updates an array-level model of the
// memory and pushes each read's expected response; a negedge monitor pops and compares.
module tb_fmap_read_responder;

    import fmap_mem_pkg::*;

    localparam int unsigned RL = 2;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct {
        bit          known;
        word_t       data;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear_start;
    logic        err_clr;
    logic        busy;
    logic        err_oob;
    logic [15:0] rd_count;

    fmap_read_responder_if bus ();

    fmap_read_responder #(
        .READ_LAT (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_start (clear_start),
        .busy        (busy),
        .err_oob     (err_oob),
        .err_clr     (err_clr),
        .rd_count    (rd_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    word_t       mem_model[int];
    bit          all_zero = 1'b0;
    bit          sweep_on = 1'b0;
    int unsigned sweep_lo = 0;
    int unsigned sweep_hi = 0;
    bit          exp_busy = 1'b0;
    bit          exp_err = 1'b0;
    bit          err_next = 1'b0;
    int unsigned exp_count = 0;
    bit          checking = 1'b0;

    function automatic word_t splat(input logic [7:0] b);
        return {LANES{b}};
    endfunction

    function automatic word_t rnd_word();
        return word_t'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic void chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (checking) begin
            chk("busy", word_t'(busy), word_t'(exp_busy));
            chk("wr_ready", word_t'(bus.wr_ready), word_t'(!exp_busy));
            chk("err_oob", word_t'(err_oob), word_t'(exp_err));
            chk("rd_count", word_t'(rd_count), word_t'(exp_count[15:0]));
            if (bus.mem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", word_t'(bus.mem_valid), word_t'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_cycle", word_t'(cyc), word_t'(e.due));
                    if (e.known) chk("resp_data", bus.mem_dout, e.data);
                end
                exp_count++;
            end else begin
                chk("dout_idle_zero", bus.mem_dout, word_t'(0));
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_valid", word_t'(bus.mem_valid), word_t'(1));
                end
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic step(input bit men, input addr_t maddr, input bit wen, input addr_t waddr,
                        input word_t wdata, input bit cs, input bit eclr);
        int unsigned q;
        bit          bnow;
        exp_t        e;
        @(posedge clk);
        #1;
        q       = cyc;
        exp_err = err_next;
        if (sweep_on && q > sweep_hi) begin
            sweep_on = 1'b0;
            mem_model.delete();
            all_zero = 1'b1;
        end
        bnow     = sweep_on && q >= sweep_lo;
        exp_busy = bnow;

        bus.mem_en   = men;
        bus.mem_addr = maddr;
        bus.wr_en    = wen;
        bus.wr_addr  = waddr;
        bus.wr_data  = wdata;
        clear_start  = cs;
        err_clr      = eclr;

        if (men) begin
            e.due = q + RL;
            if (int'(maddr) >= int'(DEPTH) || bnow) begin
                e.known = 1'b1;
                e.data  = '0;
            end else if (mem_model.exists(int'(maddr))) begin
                e.known = 1'b1;
                e.data  = mem_model[int'(maddr)];
            end else begin
                e.known = all_zero;
                e.data  = '0;
            end
            exp_q.push_back(e);
        end
        // Model applies the write after the read: read-first semantics.
        if (wen && !bnow && int'(waddr) < int'(DEPTH)) mem_model[int'(waddr)] = wdata;

        if ((men && int'(maddr) >= int'(DEPTH)) || (wen && !bnow && int'(waddr) >= int'(DEPTH)))
            err_next = 1'b1;
        else if (eclr)
            err_next = 1'b0;
        else
            err_next = exp_err;

        if (cs && !bnow) begin
            sweep_on = 1'b1;
            sweep_lo = q + 1;
            sweep_hi = q + DEPTH;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(1, addr_t'(a), 0, '0, '0, 0, 0);
    endtask

    task automatic wr(input int a, input word_t d);
        step(0, '0, 1, addr_t'(a), d, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.mem_en   = 1'b0;
        bus.wr_en    = 1'b0;
        clear_start  = 1'b0;
        err_clr      = 1'b0;
        exp_q.delete();
        mem_model.delete();
        all_zero  = 1'b0;
        sweep_on  = 1'b0;
        exp_count = 0;
        exp_busy  = 1'b0;
        exp_err   = 1'b0;
        err_next  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.mem_en   = 1'b0;
        bus.mem_addr = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        clear_start  = 1'b0;
        err_clr      = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checking = 1'b1;
        idle(2);

        // Single write then read of address 100
        wr(100, splat(8'hA5));
        rd(100);
        idle(4);

        // Load data = addr, then stream 64 back-to-back reads
        for (int a = 0; a < 64; a++) wr(a, word_t'(a));
        for (int a = 0; a < 64; a++) rd(a);
        idle(4);

        // Same-cycle read and write to 200: old value returned, new value next
        wr(200, splat(8'h22));
        idle(1);
        step(1, addr_t'(200), 1, addr_t'(200), splat(8'h11), 0, 0);
        rd(200);
        idle(4);

        // Out-of-range reads/writes and the sticky error flag
        rd(DEPTH);
        idle(2);
        step(1, addr_t'(32767), 0, '0, '0, 0, 1);
        idle(2);
        step(0, '0, 0, '0, '0, 0, 1);
        idle(2);
        wr(DEPTH + 12, rnd_word());
        idle(2);
        step(0, '0, 0, '0, '0, 0, 1);
        idle(2);

        // Randomized traffic over a fully written window with occasional bad addresses
        for (int a = 0; a < 256; a++) wr(a, rnd_word());
        for (int i = 0; i < 3000; i++) begin
            bit men, wen, eclr;
            int ra, wa;
            men  = ($urandom_range(9) < 7);
            wen  = ($urandom_range(1) == 1);
            eclr = ($urandom_range(19) == 0);
            ra   = ($urandom_range(19) == 0) ? int'($urandom_range(32767, DEPTH))
                                             : int'($urandom_range(255));
            wa   = ($urandom_range(29) == 0) ? int'($urandom_range(32767, DEPTH))
                                             : int'($urandom_range(255));
            step(men, addr_t'(ra), wen, addr_t'(wa), rnd_word(), 0, eclr);
        end
        idle(4);
        step(0, '0, 0, '0, '0, 0, 1);
        idle(2);

        // Full clear sweep with dropped writes, a repeated start, and reads during it
        step(0, '0, 0, '0, '0, 1, 0);
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            bit men, wen;
            int ra;
            men = (i == int'(DEPTH) / 2) || ($urandom_range(3) == 0);
            ra  = (i == int'(DEPTH) / 2) ? 5 : int'($urandom_range(DEPTH - 1));
            wen = ($urandom_range(1) == 1);
            step(men, addr_t'(ra), wen, addr_t'($urandom_range(255)), rnd_word(), i == 100, 0);
        end
        for (int a = 0; a < int'(DEPTH); a++) rd(a);
        idle(4);

        // Reset in the middle of a sweep with two reads in flight
        step(0, '0, 0, '0, '0, 1, 0);
        idle(500);
        rd(10);
        rd(20);
        do_reset(2);
        idle(6);
        wr(300, splat(8'h5C));
        rd(300);
        idle(5);

        chk("scoreboard_drained", word_t'(exp_q.size()), word_t'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmap_read_responder.md
# fmap_read_responder

Memory-side responder for the feature-map read interface used by the tile prefetch buffers. It accepts one read request per cycle with no backpressure and returns `LANES*DATA_W`-bit words in order after a fixed latency. It also provides a write port, which the conv output path uses to load feature maps, and a zero-clear sweep. It sits between the activation store and the prefetch double buffer.

## Interface
- `DATA_W`, 8, bits per lane
- `LANES`, 16, lanes per word; `WORD_W = DATA_W*LANES`
- `DEPTH`, 25088, words stored (112*112*(32/LANES))
- `ADDR_W`, `$clog2(DEPTH)` (15), address width
- `READ_LAT`, 2, cycles from request to response; legal range 1..4

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_en`  in  1  read request strobe
- `mem_addr`  in  ADDR_W  read word address
- `mem_dout`  out  WORD_W  read data; zero whenever `mem_valid`=0
- `mem_valid`  out  1  response strobe
- `wr_en`  in  1  write strobe
- `wr_addr`  in  ADDR_W  write word address
- `wr_data`  in  WORD_W  write data
- `wr_ready`  out  1  write port accepts `wr_en`; low while clearing
- `clear_start`  in  1  starts zero sweep of the whole array
- `busy`  out  1  clear sweep in progress
- `err_oob`  out  1  sticky: read or write with address >= DEPTH seen
- `err_clr`  in  1  clears `err_oob`
- `rd_count`  out  16  wrapping count of responses issued

## Operation
- FSM states are IDLE and CLEAR.
- IDLE -> CLEAR when `clear_start`=1. In CLEAR, `clear_start` is ignored.
- CLEAR writes zero to addresses 0..DEPTH-1 at one word per cycle, using an internal pointer.
- CLEAR -> IDLE the cycle after address DEPTH-1 is written.
- `busy`=1 and `wr_ready`=0 exactly while in CLEAR.
- Writes: accepted in IDLE when `wr_en`=1 and `wr_addr`<DEPTH. `wr_en` during CLEAR is dropped silently. An out-of-range write is dropped and sets `err_oob`.
- Reads: every `mem_en`=1 is accepted, in any state, and produces exactly one response.
  - Response data is zero if the address >= DEPTH (this also sets `err_oob`) or if the request was accepted during CLEAR.
  - Otherwise the response carries the array word.
- A read and a write to the same address in the same cycle resolve read-first: the read returns the old data.
- Responses are strictly in request order. There is no response reordering and no stall.
- `rd_count` increments on each `mem_valid` and wraps at 2^16.
- If `err_clr` and a new out-of-range event occur in the same cycle, set wins.

## Timing
- Reset values: `mem_valid`=0, `mem_dout`=0, `busy`=0, `wr_ready`=1, `err_oob`=0, `rd_count`=0. FSM resets to IDLE and the pipeline valids clear. Array contents are not reset.
- Reset mid-sweep or mid-read: the sweep is abandoned and in-flight responses are discarded. No `mem_valid` is produced for them.
- Read latency: `mem_en` sampled at edge N gives `mem_valid`=1 with data in the cycle after edge N+READ_LAT-1, i.e. READ_LAT cycles later. For READ_LAT=2, a request in cycle 0 responds in cycle 2.
- Back-to-back requests produce back-to-back responses at full throughput.
- `clear_start` seen in cycle 0 gives `busy`=1 from cycle 1 through cycle DEPTH; `busy` falls in cycle DEPTH+1.
- A write accepted in cycle 0 is visible to a read issued in cycle 1 or later.
- `err_oob` rises the cycle after the offending request is sampled.

## Structure
- Shared package `fmap_mem_pkg` holds the default `DATA_W`, `LANES` and `DEPTH`, the derived `WORD_W` and `ADDR_W`, and the FSM state enum.
- Sub-module `fmap_sdp_ram` is a simple dual-port RAM: write port and read port, read-first, 1-cycle read latency, BRAM/URAM-mappable.
- The top level holds the following:
  - the FSM and clear pointer
  - the write mux between clear and user writes
  - a READ_LAT-1 stage valid/zero-flag shift pipeline aligned with the RAM output
  - output zero gating
  - error and count logic

## Test plan
- Write 0xA5 to every lane of address 100, then read address 100 with READ_LAT=2 -> `mem_valid` exactly 2 cycles later, `mem_dout` all 0xA5, `rd_count`=1.
- Read addresses 0..63 on 64 consecutive cycles after loading data=addr -> 64 consecutive `mem_valid` pulses carrying 0..63 in order.
- Read address 200 and write 0x11 to address 200 in the same cycle (old value 0x22) -> response 0x22; the next read returns 0x11.
- Read address 25088 -> `mem_valid` with zero data and `err_oob`=1 next cycle. Then assert `err_clr` together with another out-of-range read -> `err_oob` stays 1.
- Pulse `clear_start`, attempt a write during the sweep, and read address 5 at mid-sweep -> `wr_ready`=0 and the write is dropped, the read returns zero, `busy` is high for 25088 cycles, and afterwards all addresses read zero.
- Assert `rst` mid-sweep with 2 reads in flight -> no `mem_valid` afterwards, `busy`=0 immediately, `rd_count`=0.
